// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per accepted request, bit period set by a runtime divider.
// Synchronous active-high reset on arst_n; all outputs come straight from flops.
module uart_tx #(
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 tx_en,
  input  logic [7:0]           tx_data_in,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [DIV_WIDTH-1:0]   period_q, period_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic                   serial_q, serial_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [DIV_WIDTH-1:0]   p_eff;
  logic                   bit_end;

  assign bit_end = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    p_eff    = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;

    // cnt_q holds the cycles remaining in the current bit; reload with P-1 at each bit start
    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_en) begin
          shift_d  = tx_data_in;
          period_d = p_eff;
          cnt_d    = p_eff - DIV_WIDTH'(1);
          idx_d    = '0;
          serial_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d    = period_q - DIV_WIDTH'(1);
          serial_d = shift_q[0];
          state_d  = DATA;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = period_q - DIV_WIDTH'(1);
          if (idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            idx_d    = idx_q + 3'd1;
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          serial_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected frame bits are queued when a request is driven
// and popped one bit slot at a time while the line is checked every cycle.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        tx_en;
  logic [7:0]  tx_data_in;
  logic [31:0] baud_div;
  logic        tx_serial;
  logic        tx_busy;
  logic        tx_done;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        exp_q[$];

  uart_tx #(.DIV_WIDTH(32)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .tx_en     (tx_en),
    .tx_data_in(tx_data_in),
    .baud_div  (baud_div),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      check({tag, "_serial"}, tx_serial, 1'b1);
      check({tag, "_busy"}, tx_busy, 1'b0);
      check({tag, "_done"}, tx_done, 1'b0);
      @(negedge clk);
    end
  endtask

  // Called on a negedge; the request is accepted on the following posedge.
  task automatic start_frame(input logic [7:0] d, input logic [31:0] div);
    logic [7:0] b;
    tx_en      = 1'b1;
    tx_data_in = d;
    baud_div   = div;
    b = d;
    exp_q.push_back(1'b0);
    for (int unsigned i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
    @(negedge clk);
    tx_en = 1'b0;
  endtask

  // Checks 10*p cycles of frame, then the tx_done cycle; returns on that negedge.
  // inject_at >= 0 pulses a competing request (new data and divider) at that cycle.
  task automatic drain_frame(input int unsigned p, input int inject_at, input string tag);
    logic b;
    int   cyc = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue_underflow"}, 1'b1, 1'b0);
        b = 1'b1;
      end else begin
        b = exp_q.pop_front();
      end
      for (int unsigned c = 0; c < p; c++) begin
        check({tag, "_serial"}, tx_serial, b);
        check({tag, "_busy"}, tx_busy, 1'b1);
        check({tag, "_done_early"}, tx_done, 1'b0);
        if (cyc == inject_at) begin
          tx_en      = 1'b1;
          tx_data_in = 8'h5A;
          baud_div   = 32'd7;
        end else begin
          tx_en = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    tx_en = 1'b0;
    check({tag, "_done"}, tx_done, 1'b1);
    check({tag, "_done_busy"}, tx_busy, 1'b0);
    check({tag, "_done_serial"}, tx_serial, 1'b1);
  endtask

  initial begin
    arst_n     = 1'b1;
    tx_en      = 1'b0;
    tx_data_in = '0;
    baud_div   = '0;
    repeat (2) @(negedge clk);
    check("rst_serial", tx_serial, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    arst_n = 1'b0;
    @(negedge clk);
    check_idle(3, "post_rst");

    // Single byte, P=4
    start_frame(8'hA5, 32'd4);
    drain_frame(4, -1, "a5_p4");
    @(negedge clk);
    check_idle(4, "a5_after");

    // Competing request during the data phase must be ignored entirely
    start_frame(8'hA5, 32'd4);
    drain_frame(4, 14, "busy_req");
    @(negedge clk);
    check_idle(12, "busy_after");

    // Back-to-back: second request issued in the tx_done cycle
    start_frame(8'h5A, 32'd3);
    drain_frame(3, -1, "b2b_first");
    start_frame(8'hFF, 32'd3);
    drain_frame(3, -1, "b2b_second");
    @(negedge clk);
    check_idle(3, "b2b_after");

    // Divider 0 behaves as 1
    start_frame(8'h3C, 32'd0);
    drain_frame(1, -1, "div0");
    @(negedge clk);
    check_idle(3, "div0_after");

    // Large divider exercising wide counter reloads
    start_frame(8'h5A, 32'd3000);
    drain_frame(3000, -1, "div3000");
    @(negedge clk);
    check_idle(3, "div3000_after");

    // Reset mid-DATA aborts immediately with no tx_done
    start_frame(8'hA5, 32'd4);
    repeat (9) @(negedge clk);
    check("pre_abort_busy", tx_busy, 1'b1);
    exp_q.delete();
    arst_n = 1'b1;
    @(negedge clk);
    check("abort_serial", tx_serial, 1'b1);
    check("abort_busy", tx_busy, 1'b0);
    check("abort_done", tx_done, 1'b0);
    arst_n = 1'b0;
    @(negedge clk);
    check_idle(50, "abort_after");

    // A fresh frame after the abort still works
    start_frame(8'h81, 32'd2);
    drain_frame(2, -1, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
